// File: rtl/serial_frame_receiver.sv
// Bit-serial frame receiver: start bit, WIDTH data bits LSB-first, stop bit -> parallel word.
// Latency: data_valid rises 1 clk after the stop-bit strobe; FSM advances only on bit_en.
// Backpressure: a held word is never overwritten; a frame completing while it is held sets overrun.
module serial_frame_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy,
    input  logic             err_clr
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               frame_good;
    logic               frame_bad;
    logic               accept;

    always_comb begin
        state_d    = state_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: if (!bit_in) state_d = DATA;
                DATA: if (cnt_q == LAST_BIT) state_d = STOP;
                STOP: begin
                    state_d    = IDLE;
                    frame_good = bit_in;
                    frame_bad  = !bit_in;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign accept = data_valid && data_ready;
    assign busy   = (state_q == DATA) || (state_q == STOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (bit_en) begin
                case (state_q)
                    IDLE: if (!bit_in) begin
                        cnt_q   <= '0;
                        shreg_q <= '0;
                    end
                    DATA: begin
                        shreg_q[cnt_q] <= bit_in;
                        if (cnt_q != LAST_BIT) cnt_q <= cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A completed word may replace the held one only when that one is accepted on this same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (frame_good && (!data_valid || data_ready)) begin
            data_out   <= shreg_q;
            data_valid <= 1'b1;
        end else if (accept) begin
            data_valid <= 1'b0;
        end
    end

    // Set events win over a same-edge err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_bad)    frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (frame_good && data_valid && !data_ready) overrun <= 1'b1;
            else if (err_clr)                            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver with a bit-queue reference model and per-cycle compare.
module tb_serial_frame_receiver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_in = 1'b1;
    logic         bit_en = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready = 1'b1;
    logic         frame_err;
    logic         overrun;
    logic         busy;
    logic         err_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    serial_frame_receiver #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: collect sampled bits of a frame, judge it once start+data+stop are in.
    bit           q[$];
    logic [W-1:0] m_data;
    logic         m_valid, m_ferr, m_ovr;
    logic [W-1:0] m_word;
    bit           m_good, m_bad, m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_data = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
        end else begin
            m_good = 0; m_bad = 0; m_word = '0;
            m_acc  = m_valid && data_ready;
            if (bit_en) begin
                if (q.size() != 0 || bit_in == 1'b0) q.push_back(bit_in);
                if (q.size() == W + 2) begin
                    for (int i = 0; i < W; i++) m_word[i] = q[i+1];
                    if (q[W+1]) m_good = 1; else m_bad = 1;
                    q.delete();
                end
            end
            if (err_clr) begin m_ferr = 0; m_ovr = 0; end
            if (m_bad) m_ferr = 1;
            if (m_good && (!m_valid || m_acc)) begin
                m_data = m_word; m_valid = 1;
            end else if (m_good) begin
                m_ovr = 1;
            end else if (m_acc) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model.data_valid", 32'(data_valid), 32'(m_valid));
        chk("model.data_out",   32'(data_out),   32'(m_data));
        chk("model.frame_err",  32'(frame_err),  32'(m_ferr));
        chk("model.overrun",    32'(overrun),    32'(m_ovr));
        chk("model.busy",       32'(busy),       32'(q.size() != 0));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Idle-high gap of 'gap' cycles, then a one-cycle strobe carrying b.
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) tick();
        bit_in = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        bit_in = 1'b1;
    endtask

    task automatic send_head(input logic [W-1:0] w, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) send_bit(w[i], gap);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic stop, input int gap);
        send_head(w, gap);
        send_bit(stop, gap);
    endtask

    initial begin
        #1;
        chk("reset.data_valid", 32'(data_valid), 32'd0);
        chk("reset.data_out",   32'(data_out),   32'd0);
        chk("reset.busy",       32'(busy),       32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: contiguous strobes
        send_frame(8'hA5, 1'b1, 0);
        chk("t1.valid",  32'(data_valid), 32'd1);
        chk("t1.data",   32'(data_out),   32'hA5);
        chk("t1.ferr",   32'(frame_err),  32'd0);
        tick();
        chk("t1.one_cycle", 32'(data_valid), 32'd0);

        // 2: sparse strobes with leading idle ones
        send_bit(1'b1, 3);
        send_bit(1'b1, 3);
        send_frame(8'hA5, 1'b1, 3);
        chk("t2.valid", 32'(data_valid), 32'd1);
        chk("t2.data",  32'(data_out),   32'hA5);
        tick();

        // 3: bad stop bit, recovery, err_clr
        send_frame(8'h3C, 1'b0, 0);
        chk("t3.no_valid", 32'(data_valid), 32'd0);
        chk("t3.ferr",     32'(frame_err),  32'd1);
        send_frame(8'h5A, 1'b1, 0);
        chk("t3.data",        32'(data_out),  32'h5A);
        chk("t3.ferr_sticky", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3.ferr_clr", 32'(frame_err), 32'd0);

        // 4: overrun under backpressure
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        chk("t4.valid",   32'(data_valid), 32'd1);
        chk("t4.data",    32'(data_out),   32'h11);
        chk("t4.overrun", 32'(overrun),    32'd1);
        data_ready = 1'b1;
        tick();
        chk("t4.accept", 32'(data_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4.ovr_clr", 32'(overrun), 32'd0);

        // 5: accept on the same edge as the next word completes
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        send_head(8'h22, 0);
        data_ready = 1'b1;
        send_bit(1'b1, 0);
        chk("t5.valid",   32'(data_valid), 32'd1);
        chk("t5.data",    32'(data_out),   32'h22);
        chk("t5.overrun", 32'(overrun),    32'd0);
        tick();

        // 6: async reset mid-frame
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
        chk("t6.busy_pre", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6.rst_busy",  32'(busy),       32'd0);
        chk("t6.rst_data",  32'(data_out),   32'd0);
        chk("t6.rst_valid", 32'(data_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_frame(8'hFF, 1'b1, 0);
        chk("t6.valid", 32'(data_valid), 32'd1);
        chk("t6.data",  32'(data_out),   32'hFF);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
